deflate_bit_packer: RTL and testbench

Downstream stage of the static Huffman encoders. It receives variable-length, LSB-first codes, for example the distance encoder's merged {extra bits, reversed 5-bit code} word together with its valid-bit count. It concatenates the codes into a continuous DEFLATE bitstream and emits fixed 32-bit words over a valid/ready handshake. A flush pads the final partial word with zeros and marks it last, with a byte count.

---
 rtl/deflate_bit_packer_if.sv | 28 ++
 rtl/deflate_bit_packer.sv | 80 ++++++++
 tb/tb_deflate_bit_packer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/deflate_bit_packer_if.sv
// Handshake bundle between the Huffman encoders, the bit packer and the word consumer.
// The packer uses the slave modport; the producer/consumer side uses master.
interface deflate_bit_packer_if #(
    parameter int unsigned IN_WIDTH  = 24,
    parameter int unsigned OUT_WIDTH = 32
);
    logic                 code_valid_in;
    logic                 code_ready_out;
    logic [IN_WIDTH-1:0]  code_in;
    logic [4:0]           code_len_in;
    logic                 flush_in;
    logic                 out_valid;
    logic                 out_ready_in;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic [2:0]           out_nbytes;
    logic                 flush_done_out;

    modport master (
        output code_valid_in, code_in, code_len_in, flush_in, out_ready_in,
        input  code_ready_out, out_valid, out_data, out_last, out_nbytes, flush_done_out
    );

    modport slave (
        input  code_valid_in, code_in, code_len_in, flush_in, out_ready_in,
        output code_ready_out, out_valid, out_data, out_last, out_nbytes, flush_done_out
    );
endinterface

// File: rtl/deflate_bit_packer.sv
// Concatenates LSB-first variable-length codes into a DEFLATE bitstream of fixed-width words.
// Flush zero-pads the tail word, marks it last and reports its byte count.
module deflate_bit_packer #(
    parameter int unsigned IN_WIDTH  = 24,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned BUF_WIDTH = 64
) (
    input logic             clk,
    input logic             rst_n,
    deflate_bit_packer_if.slave bus
);
    localparam int unsigned FILL_W = 7;
    localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W-1:0] ACC_MAX  = FILL_W'(BUF_WIDTH - IN_WIDTH);
    localparam logic [FILL_W-1:0] BYTE_RND = FILL_W'(7);

    typedef enum logic [1:0] {PACK, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic [BUF_WIDTH-1:0] acc_q, acc_d, acc_base, code_masked;
    logic [FILL_W-1:0]    fill_q, fill_d, fill_base;
    logic                 ready, valid, last, accept, pop;

    // Everything visible outside is decoded from state and fill only.
    assign ready  = (state_q == PACK) && (fill_q <= ACC_MAX);
    assign valid  = ((state_q == PACK) && (fill_q >= OUT_FILL)) ||
                    ((state_q == FLUSH) && (fill_q != '0));
    assign last   = (state_q == FLUSH) && (fill_q <= OUT_FILL);
    assign accept = bus.code_valid_in && ready;
    assign pop    = valid && bus.out_ready_in;

    assign code_masked = BUF_WIDTH'(bus.code_in) &
                         ((BUF_WIDTH'(1) << bus.code_len_in) - BUF_WIDTH'(1));

    assign bus.code_ready_out = ready;
    assign bus.out_valid      = valid;
    assign bus.out_data       = acc_q[OUT_WIDTH-1:0];
    assign bus.out_last       = last;
    assign bus.out_nbytes     = last ? 3'((fill_q + BYTE_RND) >> 3) : 3'(OUT_WIDTH / 8);
    assign bus.flush_done_out = (state_q == DONE);

    // Shift out a popped word first so a same-cycle append lands below the old fill.
    always_comb begin
        state_d   = state_q;
        acc_base  = acc_q;
        fill_base = fill_q;
        if (pop) begin
            acc_base  = acc_q >> OUT_WIDTH;
            fill_base = (fill_q > OUT_FILL) ? fill_q - OUT_FILL : '0;
        end
        acc_d  = acc_base;
        fill_d = fill_base;
        if (accept) begin
            acc_d  = acc_base | (code_masked << fill_base);
            fill_d = fill_base + FILL_W'(bus.code_len_in);
        end
        case (state_q)
            PACK:    if (bus.flush_in) state_d = (fill_d == '0) ? DONE : FLUSH;
            FLUSH:   if (pop && last) state_d = DONE;
            DONE: begin
                state_d = PACK;
                acc_d   = '0;
                fill_d  = '0;
            end
            default: state_d = PACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PACK;
            acc_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
        end
    end
endmodule

// File: tb/tb_deflate_bit_packer.sv
// Directed and randomized checks of deflate_bit_packer against a bit-queue stream model.
module tb_deflate_bit_packer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Reference model: the pending bitstream as a queue, plus the stream phase.
    bit   mq[$];
    int   md;  // 0 packing, 1 flushing, 2 flush complete

    deflate_bit_packer_if #(.IN_WIDTH(24), .OUT_WIDTH(32)) bus ();

    deflate_bit_packer #(.IN_WIDTH(24), .OUT_WIDTH(32), .BUF_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model.
    task automatic cycle(input logic v, input logic [23:0] c, input logic [4:0] l,
                         input logic f, input logic r);
        int          sz;
        logic        e_ready, e_valid, e_last, do_pop, do_acc;
        logic [31:0] e_data;
        logic [2:0]  e_nb;
        bus.code_valid_in = v;
        bus.code_in       = c;
        bus.code_len_in   = l;
        bus.flush_in      = f;
        bus.out_ready_in  = r;
        sz      = mq.size();
        e_ready = (md == 0) && (sz <= 40);
        e_valid = ((md == 0) && (sz >= 32)) || ((md == 1) && (sz > 0));
        e_last  = (md == 1) && (sz <= 32);
        e_nb    = e_last ? 3'((sz + 7) / 8) : 3'd4;
        e_data  = '0;
        for (int i = 0; i < 32; i++) if (i < sz) e_data[i] = mq[i];
        check("code_ready", 32'(bus.code_ready_out), 32'(e_ready));
        check("out_valid",  32'(bus.out_valid),      32'(e_valid));
        check("out_data",   bus.out_data,            e_data);
        check("out_last",   32'(bus.out_last),       32'(e_last));
        check("out_nbytes", 32'(bus.out_nbytes),     32'(e_nb));
        check("flush_done", 32'(bus.flush_done_out), 32'(md == 2));
        do_pop = e_valid && r;
        do_acc = v && e_ready;
        if (md == 2) begin
            mq.delete();
            md = 0;
        end else begin
            if (do_pop) for (int i = 0; i < 32 && mq.size() > 0; i++) void'(mq.pop_front());
            if (do_acc) for (int i = 0; i < int'(l); i++) mq.push_back(c[i]);
            if (md == 0 && f)                    md = (mq.size() == 0) ? 2 : 1;
            else if (md == 1 && do_pop && sz <= 32) md = 2;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.code_valid_in = 1'b0;
        bus.flush_in      = 1'b0;
        bus.out_ready_in  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        md = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        md       = 0;
        bus.code_in     = '0;
        bus.code_len_in = '0;
        @(negedge clk);
        do_reset();

        // Reset state.
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_last",  32'(bus.out_last), 32'd0);
        check("rst_done",  32'(bus.flush_done_out), 32'd0);
        check("rst_ready", 32'(bus.code_ready_out), 32'd1);
        check("rst_nbytes", 32'(bus.out_nbytes), 32'd4);

        // Eight nibbles form one word.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 24'(i), 5'd4, 1'b0, 1'b1);
        check("t2_valid", 32'(bus.out_valid), 32'd1);
        check("t2_data",  bus.out_data, 32'h87654321);
        check("t2_last",  32'(bus.out_last), 32'd0);
        check("t2_nbytes", 32'(bus.out_nbytes), 32'd4);
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);

        // Masking and flush of a partial word.
        cycle(1'b1, 24'hFFFFFF, 5'd5, 1'b0, 1'b1);
        cycle(1'b0, 24'd0, 5'd0, 1'b1, 1'b1);
        check("t3_data",  bus.out_data, 32'h0000001F);
        check("t3_last",  32'(bus.out_last), 32'd1);
        check("t3_nbytes", 32'(bus.out_nbytes), 32'd1);
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
        check("t3_done", 32'(bus.flush_done_out), 32'd1);
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
        check("t3_done_clr", 32'(bus.flush_done_out), 32'd0);
        check("t3_ready", 32'(bus.code_ready_out), 32'd1);

        // Backpressure: data held while stalled.
        cycle(1'b1, 24'hABCDEF, 5'd24, 1'b0, 1'b0);
        cycle(1'b1, 24'h123456, 5'd24, 1'b0, 1'b0);
        check("t4_ready_full", 32'(bus.code_ready_out), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold", bus.out_data, 32'h56ABCDEF);
            cycle(1'b1, 24'h777777, 5'd24, 1'b0, 1'b0);
        end
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
        check("t4_ready_after", 32'(bus.code_ready_out), 32'd1);
        check("t4_valid_after", 32'(bus.out_valid), 32'd0);
        check("t4_rest", bus.out_data, 32'h00001234);
        cycle(1'b0, 24'd0, 5'd0, 1'b1, 1'b1);
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);

        // Pop, append and flush in one cycle.
        cycle(1'b1, 24'h00BEEF, 5'd16, 1'b0, 1'b1);
        cycle(1'b1, 24'h00CAFE, 5'd16, 1'b0, 1'b1);
        check("t5_first_last", 32'(bus.out_last), 32'd0);
        check("t5_first_data", bus.out_data, 32'hCAFEBEEF);
        cycle(1'b1, 24'h0000A5, 5'd8, 1'b1, 1'b1);
        check("t5_data",  bus.out_data, 32'h000000A5);
        check("t5_last",  32'(bus.out_last), 32'd1);
        check("t5_nbytes", 32'(bus.out_nbytes), 32'd1);
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
        check("t5_done", 32'(bus.flush_done_out), 32'd1);
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);

        // Empty flush, then reset in the middle of a flush.
        cycle(1'b0, 24'd0, 5'd0, 1'b1, 1'b1);
        check("t6_empty_valid", 32'(bus.out_valid), 32'd0);
        check("t6_empty_done", 32'(bus.flush_done_out), 32'd1);
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
        cycle(1'b1, 24'h135790, 5'd24, 1'b0, 1'b0);
        cycle(1'b1, 24'h00ACE1, 5'd16, 1'b0, 1'b0);
        cycle(1'b0, 24'd0, 5'd0, 1'b1, 1'b0);
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b0);
        check("t6_flushing", 32'(bus.out_valid), 32'd1);
        do_reset();
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_ready", 32'(bus.code_ready_out), 32'd1);
        check("t6_rst_data", bus.out_data, 32'd0);
        cycle(1'b0, 24'd0, 5'd0, 1'b1, 1'b1);
        check("t6_rst_empty", 32'(bus.flush_done_out), 32'd1);
        cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);

        // Randomized traffic with garbage above each code length.
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(3, 0) != 0), 24'($urandom), 5'($urandom_range(24, 0)),
                  1'($urandom_range(49, 0) == 0), 1'($urandom_range(3, 0) != 0));
        end
        // Drain whatever is left.
        cycle(1'b0, 24'd0, 5'd0, 1'b1, 1'b1);
        for (int n = 0; n < 6; n++) cycle(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
